// File: rtl/ahb_slave_mem.sv
// AHB-Lite single-slave word memory: pipelined address/data phases, programmable
// wait states per OKAY transfer, and the two-cycle ERROR response for illegal accesses.
module ahb_slave_mem #(
    parameter int bus_width   = 32,
    parameter int mem_depth   = 256,
    parameter int wait_states = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [bus_width-1:0] HADDR,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [2:0]           HBURST,
    input  logic [1:0]           HTRANS,
    input  logic [bus_width-1:0] HWDATA,
    output logic [bus_width-1:0] HRDATA,
    output logic                 HREADY,
    output logic                 HRESP
);
    localparam int AW = $clog2(mem_depth);
    localparam logic [bus_width-1:0] DEPTH_W = bus_width'(mem_depth);
    localparam logic [2:0] WS_LOAD = (wait_states > 0) ? 3'(wait_states - 1) : 3'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      cnt_reg, cnt_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic            write_reg, write_next;
    logic            err_reg, err_next;
    logic            sample;
    logic            addr_err;
    logic [bus_width-1:0] mem [mem_depth];

    // Burst type and the BUSY/IDLE distinction do not change slave behaviour.
    logic unused_bits;
    assign unused_bits = ^{HBURST, HTRANS[0]};

    assign HREADY   = (state_reg != S_WAIT) && (state_reg != S_ERR1);
    assign HRESP    = (state_reg == S_ERR1) || (state_reg == S_ERR2);
    assign sample   = HREADY && HTRANS[1];
    assign addr_err = (HADDR >= DEPTH_W) || (HSIZE != 3'b010);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 3'd0;
            addr_reg  <= '0;
            write_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            write_reg <= write_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        write_next = write_reg;
        err_next   = err_reg;
        case (state_reg)
            S_WAIT: begin
                if (cnt_reg == 3'd0) state_next = S_DATA;
                else                 cnt_next   = cnt_reg - 3'd1;
            end
            S_ERR1: state_next = S_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all close with HREADY high and sample the next address.
                if (sample) begin
                    addr_next  = HADDR[AW-1:0];
                    write_next = HWRITE;
                    err_next   = addr_err;
                    if (addr_err) begin
                        state_next = S_ERR1;
                    end else if (wait_states > 0) begin
                        state_next = S_WAIT;
                        cnt_next   = WS_LOAD;
                    end else begin
                        state_next = S_DATA;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    // The async reset forces state out of DATA before any clock edge, so aborted writes never land.
    always_ff @(posedge HCLK) begin
        if (state_reg == S_DATA && write_reg)
            mem[addr_reg] <= HWDATA;
    end

    assign HRDATA = (state_reg == S_DATA && !write_reg) ? mem[addr_reg] : '0;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: a zero-wait and a three-wait-state instance share
// one AHB master; sel picks which instance the master talks to.
module tb_ahb_slave_mem;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        sel;
    logic [1:0]  htrans0, htrans3;
    logic [31:0] hrdata0, hrdata3;
    logic        hready0, hready3, hresp0, hresp3;
    logic [31:0] bus_rdata;
    logic        bus_ready, bus_resp;

    int checks = 0;
    int failures = 0;

    logic        sq_write [8];
    logic [31:0] sq_addr  [8];
    logic [2:0]  sq_size  [8];
    logic [31:0] sq_wdata [8];
    logic        sq_burst;
    logic        late_wdata;
    logic [31:0] rs_rdata [8];
    logic        rs_resp_hi [8];
    logic        rs_resp_lo [8];
    logic        rs_rd_low_nz [8];
    int          rs_waits [8];
    int          rs_cycles;

    always #5 HCLK = ~HCLK;

    assign htrans0   = sel ? 2'b00 : HTRANS;
    assign htrans3   = sel ? HTRANS : 2'b00;
    assign bus_rdata = sel ? hrdata3 : hrdata0;
    assign bus_ready = sel ? hready3 : hready0;
    assign bus_resp  = sel ? hresp3  : hresp0;

    ahb_slave_mem #(.bus_width(32), .mem_depth(256), .wait_states(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HTRANS(htrans0), .HWDATA(HWDATA),
        .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0));

    ahb_slave_mem #(.bus_width(32), .mem_depth(256), .wait_states(3)) dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HTRANS(htrans3), .HWDATA(HWDATA),
        .HRDATA(hrdata3), .HREADY(hready3), .HRESP(hresp3));

    task automatic set_beat(input int i, input logic w, input logic [31:0] a,
                            input logic [2:0] s, input logic [31:0] d);
        sq_write[i] = w;
        sq_addr[i]  = a;
        sq_size[i]  = s;
        sq_wdata[i] = d;
    endtask

    task automatic drive_addr(input int i, input logic [1:0] trans);
        HTRANS = trans;
        HADDR  = sq_addr[i];
        HWRITE = sq_write[i];
        HSIZE  = sq_size[i];
        HBURST = sq_burst ? 3'b011 : 3'b000;
    endtask

    // Pipelined master: beat i+1 address is driven during beat i data phase.
    task automatic run_seq(input int n);
        bit done;
        rs_cycles = 0;
        drive_addr(0, 2'b10);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK); #1; rs_cycles++;
            HWDATA = late_wdata ? ~sq_wdata[i] : sq_wdata[i];
            if (i + 1 < n) drive_addr(i + 1, sq_burst ? 2'b11 : 2'b10);
            else           HTRANS = 2'b00;
            rs_waits[i] = 0;
            rs_resp_lo[i] = 1'b0;
            rs_rd_low_nz[i] = 1'b0;
            done = 1'b0;
            for (int g = 0; g < 20 && !done; g++) begin
                @(negedge HCLK);
                if (bus_ready) begin
                    rs_rdata[i]   = bus_rdata;
                    rs_resp_hi[i] = bus_resp;
                    HWDATA        = sq_wdata[i];
                    done          = 1'b1;
                end else begin
                    rs_waits[i]++;
                    rs_resp_lo[i] = rs_resp_lo[i] | bus_resp;
                    if (bus_rdata != 32'h0) rs_rd_low_nz[i] = 1'b1;
                    @(posedge HCLK); #1; rs_cycles++;
                end
            end
            if (!done) begin
                checks++; failures++;
                $display("FAIL hready_timeout beat=%0d got=HREADY stuck low exp=HREADY high", i);
            end
        end
        @(posedge HCLK); #1; rs_cycles++;
    endtask

    task automatic test_reset;
        HRESETn = 1'b0;
        #12;
        checks++; if (hready0 !== 1'b1) begin failures++; $display("FAIL rst_hready0 got=%b exp=1", hready0); end
        checks++; if (hresp0 !== 1'b0) begin failures++; $display("FAIL rst_hresp0 got=%b exp=0", hresp0); end
        checks++; if (hrdata0 !== 32'h0) begin failures++; $display("FAIL rst_hrdata0 got=%h exp=0", hrdata0); end
        checks++; if (hready3 !== 1'b1) begin failures++; $display("FAIL rst_hready3 got=%b exp=1", hready3); end
        checks++; if (hresp3 !== 1'b0) begin failures++; $display("FAIL rst_hresp3 got=%b exp=0", hresp3); end
        checks++; if (hrdata3 !== 32'h0) begin failures++; $display("FAIL rst_hrdata3 got=%h exp=0", hrdata3); end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        $display("reset: outputs idle");
    endtask

    task automatic test_single;
        sel = 1'b0; sq_burst = 1'b0;
        set_beat(0, 1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF);
        run_seq(1);
        checks++; if (rs_waits[0] !== 0) begin failures++; $display("FAIL single_wr_waits got=%0d exp=0", rs_waits[0]); end
        checks++; if (rs_resp_hi[0] !== 1'b0) begin failures++; $display("FAIL single_wr_resp got=%b exp=0", rs_resp_hi[0]); end
        checks++; if (rs_rdata[0] !== 32'h0) begin failures++; $display("FAIL single_wr_hrdata got=%h exp=0", rs_rdata[0]); end
        $display("single write 0x10 <= deadbeef");
        set_beat(0, 1'b0, 32'h10, 3'b010, 32'h0);
        run_seq(1);
        checks++; if (rs_waits[0] !== 0) begin failures++; $display("FAIL single_rd_waits got=%0d exp=0", rs_waits[0]); end
        checks++; if (rs_resp_hi[0] !== 1'b0) begin failures++; $display("FAIL single_rd_resp got=%b exp=0", rs_resp_hi[0]); end
        checks++; if (rs_rdata[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rd_data got=%h exp=deadbeef", rs_rdata[0]); end
        $display("single read 0x10 -> %h", rs_rdata[0]);
    endtask

    task automatic test_burst;
        sel = 1'b0; sq_burst = 1'b1;
        for (int i = 0; i < 4; i++) set_beat(i, 1'b1, 32'h20 + 32'(i), 3'b010, 32'(i + 1));
        run_seq(4);
        checks++; if (rs_cycles !== 5) begin failures++; $display("FAIL burst_wr_cycles got=%0d exp=5", rs_cycles); end
        $display("incr4 write 0x20..0x23 cycles=%0d", rs_cycles);
        for (int i = 0; i < 4; i++) set_beat(i, 1'b0, 32'h20 + 32'(i), 3'b010, 32'h0);
        run_seq(4);
        checks++; if (rs_cycles !== 5) begin failures++; $display("FAIL burst_rd_cycles got=%0d exp=5", rs_cycles); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rs_rdata[i] !== 32'(i + 1)) begin
                failures++; $display("FAIL burst_rd_data beat=%0d got=%h exp=%h", i, rs_rdata[i], 32'(i + 1));
            end
        end
        $display("incr4 read 0x20..0x23 -> %0d %0d %0d %0d cycles=%0d",
                 rs_rdata[0], rs_rdata[1], rs_rdata[2], rs_rdata[3], rs_cycles);
        sq_burst = 1'b0;
    endtask

    task automatic test_error;
        sel = 1'b0; sq_burst = 1'b0;
        set_beat(0, 1'b0, 32'h100, 3'b010, 32'h0);
        set_beat(1, 1'b1, 32'h21, 3'b001, 32'hBAD0_BAD0);
        set_beat(2, 1'b0, 32'h21, 3'b010, 32'h0);
        run_seq(3);
        for (int b = 0; b < 2; b++) begin
            checks++; if (rs_waits[b] !== 1) begin failures++; $display("FAIL err_low_cycles beat=%0d got=%0d exp=1", b, rs_waits[b]); end
            checks++; if (rs_resp_lo[b] !== 1'b1) begin failures++; $display("FAIL err_resp_first beat=%0d got=%b exp=1", b, rs_resp_lo[b]); end
            checks++; if (rs_resp_hi[b] !== 1'b1) begin failures++; $display("FAIL err_resp_second beat=%0d got=%b exp=1", b, rs_resp_hi[b]); end
            checks++; if (rs_rdata[b] !== 32'h0) begin failures++; $display("FAIL err_hrdata beat=%0d got=%h exp=0", b, rs_rdata[b]); end
        end
        checks++; if (rs_resp_hi[2] !== 1'b0) begin failures++; $display("FAIL err_after_resp got=%b exp=0", rs_resp_hi[2]); end
        checks++; if (rs_rdata[2] !== 32'h2) begin failures++; $display("FAIL err_after_data got=%h exp=2", rs_rdata[2]); end
        $display("error read 0x100, error write hsize=1, read 0x21 -> %h", rs_rdata[2]);
    endtask

    task automatic test_back_to_back;
        sel = 1'b0; sq_burst = 1'b0;
        set_beat(0, 1'b1, 32'h30, 3'b010, 32'hA5A5_A5A5);
        set_beat(1, 1'b0, 32'h30, 3'b010, 32'h0);
        run_seq(2);
        checks++; if (rs_rdata[1] !== 32'hA5A5_A5A5) begin failures++; $display("FAIL b2b_data got=%h exp=a5a5a5a5", rs_rdata[1]); end
        checks++; if (rs_cycles !== 3) begin failures++; $display("FAIL b2b_cycles got=%0d exp=3", rs_cycles); end
        $display("write 0x30 then read 0x30 -> %h", rs_rdata[1]);
    endtask

    task automatic test_wait_states;
        sel = 1'b1; sq_burst = 1'b0;
        late_wdata = 1'b1;
        set_beat(0, 1'b1, 32'h20, 3'b010, 32'h1);
        run_seq(1);
        late_wdata = 1'b0;
        checks++; if (rs_waits[0] !== 3) begin failures++; $display("FAIL ws_wr_waits got=%0d exp=3", rs_waits[0]); end
        checks++; if (rs_resp_hi[0] !== 1'b0) begin failures++; $display("FAIL ws_wr_resp got=%b exp=0", rs_resp_hi[0]); end
        $display("ws3 write 0x20 <= 1 waits=%0d", rs_waits[0]);
        set_beat(0, 1'b0, 32'h20, 3'b010, 32'h0);
        run_seq(1);
        checks++; if (rs_waits[0] !== 3) begin failures++; $display("FAIL ws_rd_waits got=%0d exp=3", rs_waits[0]); end
        checks++; if (rs_rdata[0] !== 32'h1) begin failures++; $display("FAIL ws_rd_data got=%h exp=1", rs_rdata[0]); end
        checks++; if (rs_resp_lo[0] !== 1'b0) begin failures++; $display("FAIL ws_rd_resp_wait got=%b exp=0", rs_resp_lo[0]); end
        checks++; if (rs_rd_low_nz[0] !== 1'b0) begin failures++; $display("FAIL ws_rd_hrdata_wait got=%b exp=0", rs_rd_low_nz[0]); end
        checks++; if (rs_cycles !== 5) begin failures++; $display("FAIL ws_rd_cycles got=%0d exp=5", rs_cycles); end
        $display("ws3 read 0x20 -> %h waits=%0d", rs_rdata[0], rs_waits[0]);
    endtask

    task automatic test_reset_mid;
        sel = 1'b1; sq_burst = 1'b0;
        set_beat(0, 1'b1, 32'h40, 3'b010, 32'h1111_1111);
        run_seq(1);
        HTRANS = 2'b10; HADDR = 32'h40; HWRITE = 1'b1; HSIZE = 3'b010; HBURST = 3'b000;
        @(posedge HCLK); #1;
        HTRANS = 2'b00;
        HWDATA = 32'h2222_2222;
        @(negedge HCLK);
        checks++; if (hready3 !== 1'b0) begin failures++; $display("FAIL midrst_in_wait got=%b exp=0", hready3); end
        #1 HRESETn = 1'b0;
        #1;
        checks++; if (hready3 !== 1'b1) begin failures++; $display("FAIL midrst_hready got=%b exp=1", hready3); end
        checks++; if (hresp3 !== 1'b0) begin failures++; $display("FAIL midrst_hresp got=%b exp=0", hresp3); end
        checks++; if (hrdata3 !== 32'h0) begin failures++; $display("FAIL midrst_hrdata got=%h exp=0", hrdata3); end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        set_beat(0, 1'b0, 32'h40, 3'b010, 32'h0);
        run_seq(1);
        checks++; if (rs_rdata[0] !== 32'h1111_1111) begin failures++; $display("FAIL midrst_read got=%h exp=11111111", rs_rdata[0]); end
        $display("reset during wait of write 0x40, read 0x40 -> %h", rs_rdata[0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b0; sq_burst = 1'b0; late_wdata = 1'b0;
        HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'b010; HBURST = 3'b000; HWDATA = '0;
        test_reset();
        test_single();
        test_burst();
        test_error();
        test_back_to_back();
        test_wait_states();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
